sar_adc_ctrl: RTL
=================

SAR_ADC_CTRL -- requirements
Module: sar_adc_ctrl

Interface
REQ-001 Parameter SAMPLE_CYCLES, default 4: number of cycles the sample-and-hold is held in track, minimum 1.
REQ-002 Parameter SETTLE_CYCLES, default 2: DAC settle cycles per bit trial, minimum 2 to cover the comparator synchroniser.
REQ-003 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port ctrl_reg, input, 12: control word from the SPI slave; bit0 ENABLE, bit1 START, bit2 CONT, bit3 AVG.
REQ-006 Port comp_in, input, 1: asynchronous analog comparator output; 1 means Vin >= DAC voltage.
REQ-007 Port dac_code, output, 12: trial code driven to the capacitive DAC.
REQ-008 Port sample_en, output, 1: sample-and-hold track enable.
REQ-009 Port adc_data, output, 12: last completed conversion result.
REQ-010 Port adc_busy, output, 1: conversion in progress.
REQ-011 Port adc_eoc, output, 1: one-cycle end-of-conversion pulse.
REQ-012 Port hw_clear_start, output, 1: one-cycle request to the SPI slave to clear the START bit.

Function
REQ-013 FSM states: IDLE, SAMPLE, CONVERT, DONE.
REQ-014 IDLE->SAMPLE when ENABLE=1 and START=1; hw_clear_start pulses for exactly that transition cycle.
REQ-015 START=1 with ENABLE=0 is ignored: no transition and no hw_clear_start pulse.
REQ-016 SAMPLE lasts SAMPLE_CYCLES cycles with sample_en=1; sample_en=0 in all other states.
REQ-017 CONVERT evaluates bits 11 down to 0; each bit period is SETTLE_CYCLES+1 cycles.
REQ-018 Bit period sequence: first cycle drives dac_code = kept bits | trial bit; last cycle reads the synchronised comparator; comp=1 keeps the bit, otherwise it is cleared.
REQ-019 comp_in passes through a 2-flop synchroniser before any use.
REQ-020 After bit 0 the FSM enters DONE for 1 cycle: adc_data is updated, adc_eoc=1, and the next state is IDLE.
REQ-021 Latency: with the start detected in IDLE at cycle T, adc_eoc is high at cycle T+1+SAMPLE_CYCLES+12*(SETTLE_CYCLES+1); with defaults this is T+41.
REQ-022 adc_busy=1 in SAMPLE and CONVERT, and 0 in IDLE and DONE.
REQ-023 If CONT=1 and ENABLE=1 in DONE, the next state is SAMPLE (no START needed, no hw_clear_start); default free-run period is 41 cycles.
REQ-024 ENABLE=0 in SAMPLE or CONVERT aborts to IDLE next cycle: no adc_eoc, adc_data unchanged, dac_code=0.
REQ-025 adc_data holds its value between DONE cycles; dac_code returns to 0 in IDLE.
REQ-026 ctrl_reg changes other than ENABLE during a conversion take effect at the next IDLE/DONE decision.

Reset
REQ-027 On reset, at any point: state IDLE; dac_code, adc_data, sample_en, adc_busy, adc_eoc, hw_clear_start, synchroniser and accumulator are all 0.
REQ-028 Reset mid-CONVERT produces no adc_eoc and no hw_clear_start after release.

Configuration
REQ-029 Macro SAR_ADC_AVG_EN defined: AVG=1 runs 4 back-to-back SAMPLE+CONVERT passes into a 14-bit accumulator.
REQ-030 With SAR_ADC_AVG_EN, adc_data = accumulator[13:2] (truncating), with a single adc_eoc after the 4th pass; adc_busy stays high between passes.
REQ-031 Macro SAR_ADC_AVG_EN undefined: AVG is ignored, no accumulator or pass counter is built, and every conversion is a single pass.
REQ-032 Abort or reset during an averaging run discards the partial sum.

Structure
REQ-033 Package sar_adc_pkg holds: the state enum, ctrl bit indices (CTRL_ENABLE=0, CTRL_START=1, CTRL_CONT=2, CTRL_AVG=3), ADC_BITS=12, and the averaging pass count 4.
REQ-034 Sub-module sar_comp_sync (2-flop synchroniser with async active-high reset) is instantiated once for comp_in.

Verification
REQ-035 Comparator model with Vin=0xA5C, ctrl=0x003: hw_clear_start pulses at T, adc_eoc at T+41, adc_data=0xA5C, adc_busy low at T+41.
REQ-036 Vin=0xFFF gives adc_data=0xFFF; Vin=0x000 gives adc_data=0x000; dac_code sequence for 0x000 starts 0x800, 0x400, ...
REQ-037 ctrl=0x007 with Vin=0x123: adc_eoc every 41 cycles, exactly one hw_clear_start, and clearing ENABLE stops it without a partial result.
REQ-038 ENABLE cleared at T+20: IDLE at T+21, no adc_eoc, adc_data retains the prior 0xA5C.
REQ-039 SAR_ADC_AVG_EN, ctrl=0x00B, pass codes 0x100/0x102/0x104/0x106: one adc_eoc, adc_data=0x103.
REQ-040 Reset pulsed at T+25 mid-CONVERT: all outputs 0 immediately; after release with START still 1 and ENABLE 1, a new conversion starts with hw_clear_start.

Source files
------------

// File: rtl/sar_adc_pkg.sv
// Shared types and constants for the SAR ADC controller.
package sar_adc_pkg;

  localparam int ADC_BITS    = 12;
  localparam int BIT_W       = $clog2(ADC_BITS);
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_CONT   = 2;
  localparam int CTRL_AVG    = 3;
  localparam int AVG_PASSES  = 4;
  localparam int PASS_W      = $clog2(AVG_PASSES);
  localparam int ACC_BITS    = ADC_BITS + PASS_W;

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } state_e;

endpackage

// File: rtl/sar_comp_sync.sv
// Two-flop synchroniser bringing the asynchronous comparator output into clk.
module sar_comp_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation ADC controller: track, 12 binary bit trials, publish.
// Optional 4-pass averaging is built only when SAR_ADC_AVG_EN is defined.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [11:0]         ctrl_reg,
  input  logic                comp_in,
  output logic [ADC_BITS-1:0] dac_code,
  output logic                sample_en,
  output logic [ADC_BITS-1:0] adc_data,
  output logic                adc_busy,
  output logic                adc_eoc,
  output logic                hw_clear_start
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES + 1;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [ADC_BITS-1:0] result_q, result_d;
  logic [ADC_BITS-1:0] adc_data_q, adc_data_d;
  logic [ADC_BITS-1:0] trial_mask, decided;
  logic                comp_sync, en, start, cont, launch, abort;
  logic                ctrl_unused;

  assign en    = ctrl_reg[CTRL_ENABLE];
  assign start = ctrl_reg[CTRL_START];
  assign cont  = ctrl_reg[CTRL_CONT];
  assign ctrl_unused = ^ctrl_reg[11:CTRL_AVG];

  sar_comp_sync u_comp_sync (
    .clk     (clk),
    .reset   (reset),
    .async_i (comp_in),
    .sync_o  (comp_sync)
  );

  assign trial_mask = ADC_BITS'(1) << bit_q;
  assign decided    = comp_sync ? (result_q | trial_mask) : result_q;

`ifdef SAR_ADC_AVG_EN
  logic                avg_q, avg_d;
  logic [PASS_W-1:0]   pass_q, pass_d;
  logic [ACC_BITS-1:0] acc_q, acc_d, acc_sum;

  assign acc_sum = acc_q + ACC_BITS'(decided);
`endif

  always_comb begin
    // NOTE: every variable gets its default first so no latch can be inferred.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    result_d   = result_q;
    adc_data_d = adc_data_q;
    launch     = 1'b0;
    abort      = 1'b0;
`ifdef SAR_ADC_AVG_EN
    avg_d  = avg_q;
    pass_d = pass_q;
    acc_d  = acc_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en && start) launch = 1'b1;
      end
      SAMPLE: begin
        if (!en) begin
          abort = 1'b1;
        end else if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_d  = CONVERT;
          cnt_d    = '0;
          bit_d    = BIT_W'(ADC_BITS - 1);
          result_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONVERT: begin
        if (!en) begin
          abort = 1'b1;
        end else if (cnt_q == CNT_W'(SETTLE_CYCLES)) begin
          result_d = decided;
          cnt_d    = '0;
          if (bit_q != '0) begin
            bit_d = bit_q - 1'b1;
          end else begin
`ifdef SAR_ADC_AVG_EN
            if (avg_q && pass_q != PASS_W'(AVG_PASSES - 1)) begin
              acc_d   = acc_sum;
              pass_d  = pass_q + 1'b1;
              state_d = SAMPLE;
            end else begin
              adc_data_d = avg_q ? acc_sum[ACC_BITS-1 -: ADC_BITS] : decided;
              state_d    = DONE;
            end
`else
            adc_data_d = decided;
            state_d    = DONE;
`endif
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        cnt_d = '0;
        if (en && cont) launch = 1'b1;
        else            state_d = IDLE;
      end
    endcase

    if (launch) state_d = SAMPLE;
    if (abort) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = '0;
    end
`ifdef SAR_ADC_AVG_EN
    // A new run latches AVG; an abort throws away any partial sum.
    if (launch) avg_d = ctrl_reg[CTRL_AVG];
    if (launch || abort) begin
      pass_d = '0;
      acc_d  = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      result_q   <= '0;
      adc_data_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      result_q   <= result_d;
      adc_data_q <= adc_data_d;
    end
  end

`ifdef SAR_ADC_AVG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avg_q  <= 1'b0;
      pass_q <= '0;
      acc_q  <= '0;
    end else begin
      avg_q  <= avg_d;
      pass_q <= pass_d;
      acc_q  <= acc_d;
    end
  end
`endif

  assign dac_code  = (state_q == CONVERT) ? (result_q | trial_mask) : '0;
  assign sample_en = (state_q == SAMPLE);
  assign adc_busy  = (state_q == SAMPLE) || (state_q == CONVERT);
  assign adc_eoc   = (state_q == DONE);
  assign adc_data  = adc_data_q;
  // Gated by reset so the request cannot reach the SPI slave while held in reset.
  assign hw_clear_start = !reset && (state_q == IDLE) && en && start;

endmodule
